bk_multiword_adder: RTL and testbench
=====================================

BK_MULTIWORD_ADDER -- requirements
Module: bk_multiword_adder

Interface
REQ-001 SHALL have parameter NW, default 4, meaning the number of 16-bit slices (operand width = 16*NW); legal range 2..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a  input  16*NW  operand A.
REQ-005 SHALL have port b  input  16*NW  operand B.
REQ-006 SHALL have port cin  input  1  carry-in to slice 0.
REQ-007 SHALL have port in_valid  input  1  operands and cin are valid.
REQ-008 SHALL have port in_ready  output  1  block can accept operands.
REQ-009 SHALL have port sum  output  16*NW  registered result.
REQ-010 SHALL have port c_out  output  1  registered carry-out of the top slice.
REQ-011 SHALL have port out_valid  output  1  sum and c_out are valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE, and SHALL treat an accept as in_valid && in_ready at a rising edge.
REQ-015 On accept, SHALL latch a, b and cin into internal registers, clear the slice index, and go to RUN.
REQ-016 In RUN, each cycle SHALL add slice k (bits 16k+15..16k) of the latched a and b with the carry register through one 16-bit adder instance; SHALL write the 16-bit result into the slice-k field of sum; SHALL load the slice carry-out into the carry register; SHALL increment k.
REQ-017 When k = NW-1 completes, SHALL load c_out from the final carry, go to DONE, and assert out_valid.
REQ-018 Latency SHALL be exactly NW cycles from the accept edge to the edge at which out_valid rises; throughput SHALL be one operation per NW+1 cycles minimum.
REQ-019 In DONE, sum, c_out and out_valid SHALL hold stable while out_ready = 0; on out_valid && out_ready the block SHALL return to IDLE, with in_ready high the next cycle.
REQ-020 SHALL ignore in_valid while in RUN or DONE; operands changing during RUN SHALL NOT affect the result.
REQ-021 Arithmetic SHALL be unsigned modulo 2^(16*NW), with c_out the carry out of bit 16*NW-1.
REQ-022 SHALL update sum slices not yet processed in the current operation only when their own RUN cycle executes; out_valid = 0 makes their contents don't-care.

Reset
REQ-023 While rst = 1, SHALL force state IDLE, in_ready = 1, out_valid = 0, sum = 0, c_out = 0, carry = 0 and k = 0, asynchronously.
REQ-024 Reset asserted mid-RUN or in DONE SHALL discard the operation with no result produced; the first accept after release SHALL start a fresh operation.

Configuration
REQ-025 With macro BK_ADDER_OVF_EN defined, SHALL add port ovf  output  1, registered with c_out, equal to signed two's-complement overflow (a MSB = b MSB and sum MSB differs from it); ovf SHALL reset to 0.
REQ-026 Without BK_ADDER_OVF_EN, port ovf and its logic SHALL be absent.

Structure
REQ-027 The shared package SHALL hold the slice width constant SLICE_W = 16 and the FSM state enum (IDLE, RUN, DONE).
REQ-028 The 16-bit slice SHALL be a separate sub-module bk_slice16: a combinational Brent-Kung prefix adder with inputs a[15:0], b[15:0] and cin, and outputs sum[15:0] and c_out; it SHALL be instantiated once and time-multiplexed.

Verification
REQ-029 NW=4: a = 0xFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1 -> after 4 cycles sum = 0, c_out = 1 (carry ripples across every slice).
REQ-030 a = 0x0000_0000_0001_FFFF, b = 0x0000_0000_0000_0001, cin = 0 -> sum = 0x0000_0000_0002_0000, c_out = 0; out_valid rises exactly 4 cycles after accept.
REQ-031 Hold out_ready = 0 for 10 cycles in DONE -> sum, c_out and out_valid stay constant and in_ready = 0; out_ready pulse -> IDLE with in_ready = 1 the next cycle.
REQ-032 Assert rst at RUN k = 2 -> all outputs reset immediately; next operation 5 + 7 returns sum = 12, c_out = 0.
REQ-033 in_valid held high with changing operands during RUN -> only the accepted operands determine sum; back-to-back operations show one accept per NW+1 cycles.
REQ-034 With BK_ADDER_OVF_EN: 0x7FFF_FFFF_FFFF_FFFF + 1 -> ovf = 1, c_out = 0; 0xFFFF_FFFF_FFFF_FFFF + 1 -> ovf = 0, c_out = 1.

Source files
------------

// File: rtl/bk_multiword_adder_pkg.sv
// bk_multiword_adder_pkg: shared slice width and FSM state type for bk_multiword_adder
package bk_multiword_adder_pkg;
  localparam int SLICE_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/bk_slice16.sv
// bk_slice16: combinational 16-bit Brent-Kung prefix adder (a, b, cin -> sum, c_out)
module bk_slice16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] p, gg, pp;
  always_comb begin
    p  = a ^ b;
    pp = p;
    gg = a & b;
    gg[0] = gg[0] | (p[0] & cin);
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 16; i++)
        if ((i % (2 << l)) == (2 << l) - 1) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
    for (int l = 2; l >= 0; l--)
      for (int i = 0; i < 16; i++)
        if (i >= (2 << l) && (i % (2 << l)) == (1 << l) - 1) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
    sum   = p ^ {gg[14:0], cin};
    c_out = gg[15];
  end
endmodule

// File: rtl/bk_multiword_adder.sv
// bk_multiword_adder: NW x 16-bit slice-serial adder (a,b,cin in; sum,c_out out; valid/ready both sides; ovf with BK_ADDER_OVF_EN)
module bk_multiword_adder
  import bk_multiword_adder_pkg::*;
#(
  parameter int NW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLICE_W*NW-1:0] a,
  input  logic [SLICE_W*NW-1:0] b,
  input  logic                  cin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SLICE_W*NW-1:0] sum,
  output logic                  c_out,
  output logic                  out_valid,
`ifdef BK_ADDER_OVF_EN
  output logic                  ovf,
`endif
  input  logic                  out_ready
);
  localparam int W  = SLICE_W * NW;
  localparam int KW = $clog2(NW);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, c_out_q, c_out_d;
  logic [KW-1:0] k_q, k_d;
  logic [SLICE_W-1:0] s_sum;
  logic s_co;
`ifdef BK_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  bk_slice16 u_slice (
    .a     (a_q[k_q*SLICE_W +: SLICE_W]),
    .b     (b_q[k_q*SLICE_W +: SLICE_W]),
    .cin   (carry_q),
    .sum   (s_sum),
    .c_out (s_co)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    k_d     = k_q;
`ifdef BK_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[k_q*SLICE_W +: SLICE_W] = s_sum;
        carry_d = s_co;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NW - 1)) begin
          c_out_d = s_co;
          k_d     = '0;
          state_d = DONE;
`ifdef BK_ADDER_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (s_sum[SLICE_W-1] != a_q[W-1]);
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      k_q     <= '0;
`ifdef BK_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      k_q     <= k_d;
`ifdef BK_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
endmodule

// File: tb/tb_bk_multiword_adder.sv
// tb_bk_multiword_adder: table-driven scoreboard bench for bk_multiword_adder (NW=4)
module tb_bk_multiword_adder;
  localparam int NW = 4;
  localparam int W  = 16 * NW;
  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;
  typedef struct {
    logic [W-1:0] s;
    logic         c, o;
    int           acc;
  } exp_t;
  logic clk = 0, rst = 1, cin = 0, in_valid = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, c_out, out_valid;
  logic [W-1:0] sum;
  logic ovf;
  int errors = 0, checks = 0, cyc = 0, rise_cyc = 0;
  logic ov_prev = 0;
  exp_t q[$];
  vec_t tbl[10];
  bk_multiword_adder #(.NW(NW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .c_out(c_out), .out_valid(out_valid),
`ifdef BK_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .out_ready(out_ready)
  );
`ifndef BK_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (rst) ov_prev = 0;
    else begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("c_out", W'(c_out), W'(e.c));
          chk("latency", W'(rise_cyc - e.acc), W'(NW));
`ifdef BK_ADDER_OVF_EN
          chk("ovf", W'(ovf), W'(e.o));
`endif
        end
      end
    end
  end
  task automatic push(input vec_t v);
    exp_t e;
    e.s = v.s; e.c = v.c; e.o = v.o; e.acc = cyc + 1;
    q.push_back(e);
  endtask
  task automatic op1(input vec_t v, input bit do_push);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("in_ready_timeout", 0, 1);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1;
    if (do_push) push(v);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic stream(input int lo, input int hi);
    int i = lo, g = 0, last = -1;
    while (i <= hi && g < 1000) begin
      @(negedge clk); g++;
      if (in_ready) begin
        a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; in_valid = 1;
        if (last >= 0) chk("accept_spacing_ok", W'(cyc + 1 - last >= NW + 1), 1);
        last = cyc + 1;
        push(tbl[i]);
        i++;
      end else begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); in_valid = 1;
      end
    end
    if (g >= 1000) chk("stream_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
    if (q.size() != 0) chk("drain_timeout", W'(q.size()), 0);
  endtask
  initial begin
    vec_t v;
    int g;
    logic [W:0] t;
    tbl[0] = '{{W{1'b1}}, '0, 1'b1, '0, 1'b1, 1'b0};
    tbl[1] = '{64'h0000_0000_0001_FFFF, 64'h1, 1'b0, 64'h0000_0000_0002_0000, 1'b0, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{{W{1'b1}}, 64'h1, 1'b0, '0, 1'b1, 1'b0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, '0, 1'b1, 1'b1};
    for (int i = 5; i < 10; i++) begin
      tbl[i].a = {$urandom, $urandom};
      tbl[i].b = {$urandom, $urandom};
      tbl[i].cin = 1'($urandom);
      t = {1'b0, tbl[i].a} + {1'b0, tbl[i].b} + (W+1)'(tbl[i].cin);
      tbl[i].s = t[W-1:0];
      tbl[i].c = t[W];
      tbl[i].o = (tbl[i].a[W-1] == tbl[i].b[W-1]) && (tbl[i].s[W-1] != tbl[i].a[W-1]);
    end
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", W'(c_out), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    stream(0, 9);
    drain();
    out_ready = 0;
    op1(tbl[1], 1);
    g = 0;
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_sum", sum, tbl[1].s);
      chk("hold_c_out", W'(c_out), W'(tbl[1].c));
      chk("hold_out_valid", W'(out_valid), 1);
      chk("hold_in_ready", W'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_pop_in_ready", W'(in_ready), 1);
    chk("post_pop_out_valid", W'(out_valid), 0);
    chk("hold_popped", W'(q.size()), 0);
    out_ready = 1;
    v = '{64'hABCD_1234_5678_9ABC, 64'h1111_2222_3333_4444, 1'b1, '0, 1'b0, 1'b0};
    op1(v, 0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    #1;
    chk("midrun_rst_in_ready", W'(in_ready), 1);
    chk("midrun_rst_out_valid", W'(out_valid), 0);
    chk("midrun_rst_sum", sum, 0);
    chk("midrun_rst_c_out", W'(c_out), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_result_after_rst", W'(out_valid), 0);
    end
    v = '{64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0};
    op1(v, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
